fifo_fwft_rd_adapter: RTL and testbench

FIFO_FWFT_RD_ADAPTER -- requirements
Module: fifo_fwft_rd_adapter

---
 rtl/fifo_fwft_rd_adapter.sv | 113 +++++++++++
 tb/tb_fifo_fwft_rd_adapter.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fifo_fwft_rd_adapter.sv
// fifo_fwft_rd_adapter
// Turns a FIFO read port into a first-word-fall-through valid/ready stream.
// The FIFO read port has rempty, r_en, and rdata that arrives RD_LATENCY
// cycles after an accepted read.
//
// The block keeps a small D = RD_LATENCY+2 entry skid buffer. A read is only
// issued when the words already buffered plus the reads still in flight
// leave a free slot. Landing data therefore always has a home, and r_en never
// depends on m_ready.
//
// Optional build macro FWFT_LEVEL_EN adds a registered fwft_level output.
// That output reports the buffered plus in-flight word count.
module fifo_fwft_rd_adapter #(
  parameter  int DATA_WIDTH = 16,
  parameter  int RD_LATENCY = 2,
  localparam int D          = RD_LATENCY + 2,
  localparam int CW         = $clog2(D + 1),
  localparam int PW         = $clog2(D)
) (
  input  logic                  rclk,
  input  logic                  rrst_n,
  input  logic                  rempty,
  output logic                  r_en,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data
`ifdef FWFT_LEVEL_EN
  ,
  output logic [CW-1:0]         fwft_level
`endif
);

  logic [RD_LATENCY-1:0] pipe;
  logic [CW-1:0]         occ;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         level;
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [DATA_WIDTH-1:0] mem [D];
  logic                  issue;
  logic                  land;
  logic                  pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  // Count reads still travelling through the RAM latency pipe
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CW'(pipe[i]);
    end
  end

  // Read issue comes from registered state only; the stream side sees the buffer head
  always_comb begin
    level   = occ + inflight;
    r_en    = rrst_n && !rempty && (level < CW'(D));
    issue   = r_en;
    land    = pipe[RD_LATENCY-1];
    m_valid = (occ != '0);
    pop     = m_valid && m_ready;
    m_data  = mem[head];
  end

  // Latency pipe, occupancy and circular pointers; reset drops everything in flight
  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      pipe <= '0;
      occ  <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      pipe <= (pipe << 1) | RD_LATENCY'(issue);
      case ({land, pop})
        2'b10:   occ <= occ + CW'(1);
        2'b01:   occ <= occ - CW'(1);
        default: occ <= occ;
      endcase
      if (land) tail <= ptr_inc(tail);
      if (pop)  head <= ptr_inc(head);
    end
  end

  // Landing RAM data is captured at the tail; storage itself is never cleared
  always_ff @(posedge rclk) begin
    if (rrst_n && land) mem[tail] <= rdata;
  end

`ifdef FWFT_LEVEL_EN
  logic [CW-1:0] level_next;

  // Next-cycle level so the registered output tracks occ + inflight exactly
  always_comb begin
    level_next = level + CW'(issue) - CW'(pop);
  end

  // Registered level report
  always_ff @(posedge rclk) begin
    if (!rrst_n) fwft_level <= '0;
    else         fwft_level <= level_next;
  end
`endif

  a_land_has_room: assert property (@(posedge rclk) disable iff (!rrst_n)
    !(land && !pop && occ == CW'(D)));

  a_level_bounded: assert property (@(posedge rclk) disable iff (!rrst_n)
    level <= CW'(D));

endmodule

// File: tb/tb_fifo_fwft_rd_adapter.sv
// tb_fifo_fwft_rd_adapter
// Exercises the FWFT adapter against a queue-based reference model.
// The FIFO is modelled as a queue of words, and the latent RAM as a list of
// words due at future cycles. The expected stream is the list of issued words
// in issue order. Each word becomes visible RD_LATENCY+1 cycles after its
// read was issued.
module tb_fifo_fwft_rd_adapter;

  localparam int DW = 16;
  localparam int L  = 2;
  localparam int D  = L + 2;
  localparam int CW = $clog2(D + 1);

  logic          rclk    = 1'b0;
  logic          rrst_n  = 1'b0;
  logic          rempty  = 1'b1;
  logic          r_en;
  logic [DW-1:0] rdata   = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
`ifdef FWFT_LEVEL_EN
  logic [CW-1:0] fwft_level;
`endif

  always #5 rclk = ~rclk;

  fifo_fwft_rd_adapter #(
    .DATA_WIDTH(DW),
    .RD_LATENCY(L)
  ) dut (
    .rclk    (rclk),
    .rrst_n  (rrst_n),
    .rempty  (rempty),
    .r_en    (r_en),
    .rdata   (rdata),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data)
`ifdef FWFT_LEVEL_EN
    ,
    .fwft_level(fwft_level)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } ent_t;

  logic [DW-1:0] fifo_q[$];
  ent_t          sb[$];
  ent_t          pend[$];
  int            cycle     = 0;
  int            tests     = 0;
  int            fails     = 0;
  int            ren_count = 0;
  int            delivered = 0;
  logic [DW-1:0] next_word = 16'h0001;

  // Compare one observed value against the model and report mismatches
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, got, exp, cycle);
    end
  endtask

  task automatic pushWords(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(next_word);
      next_word = next_word + 16'h0001;
    end
  endtask

  // Drive one cycle, check outputs against the model, then advance the model
  task automatic applyStimulus(input logic ready, input logic rst_n);
    logic exp_ren;
    logic exp_valid;
    logic pop;
    ent_t e;
    @(negedge rclk);
    rrst_n  = rst_n;
    m_ready = ready;
    rempty  = (fifo_q.size() == 0);
    rdata   = DW'($urandom);
    while (pend.size() > 0 && pend[0].cyc < cycle) void'(pend.pop_front());
    if (pend.size() > 0 && pend[0].cyc == cycle) rdata = pend[0].data;
    #1;
    exp_ren   = rst_n && (fifo_q.size() > 0) && (sb.size() < D);
    exp_valid = (sb.size() > 0) && (sb[0].cyc + L + 1 <= cycle);
    if (cycle > 0) begin
      checkOutput("r_en", 32'(r_en), 32'(exp_ren));
      checkOutput("m_valid", 32'(m_valid), 32'(exp_valid));
      if (exp_valid) checkOutput("m_data", 32'(m_data), 32'(sb[0].data));
`ifdef FWFT_LEVEL_EN
      checkOutput("fwft_level", 32'(fwft_level), 32'(sb.size()));
`endif
    end
    if (r_en) ren_count++;
    if (m_valid && ready) delivered++;
    pop = exp_valid && ready;
    if (pop) void'(sb.pop_front());
    if (exp_ren) begin
      e.data = fifo_q.pop_front();
      e.cyc  = cycle;
      sb.push_back(e);
      e.cyc  = cycle + L;
      pend.push_back(e);
    end
    if (!rst_n) begin
      sb.delete();
      fifo_q.delete();
    end
    @(posedge rclk);
    cycle++;
  endtask

  initial begin
    int d0;

    // Reset and idle
    repeat (3) applyStimulus(1'b0, 1'b0);
    repeat (2) applyStimulus(1'b1, 1'b1);

    // Eight words streamed with the sink always ready
    d0 = delivered;
    pushWords(8);
    repeat (16) applyStimulus(1'b1, 1'b1);
    checkOutput("stream8_count", 32'(delivered - d0), 32'd8);

    // Stalled sink with ten words waiting: exactly D reads, then hold
    ren_count = 0;
    d0 = delivered;
    pushWords(10);
    repeat (12) applyStimulus(1'b0, 1'b1);
    checkOutput("stall_reads", 32'(ren_count), 32'(D));
    repeat (20) applyStimulus(1'b1, 1'b1);
    checkOutput("stall_count", 32'(delivered - d0), 32'd10);

    // Alternating backpressure over twenty words
    d0 = delivered;
    pushWords(20);
    for (int i = 0; i < 60; i++) applyStimulus(logic'(i % 2 == 0), 1'b1);
    checkOutput("toggle_count", 32'(delivered - d0), 32'd20);

    // Single word written into an empty FIFO
    ren_count = 0;
    d0 = delivered;
    pushWords(1);
    repeat (8) applyStimulus(1'b1, 1'b1);
    checkOutput("single_reads", 32'(ren_count), 32'd1);
    checkOutput("single_count", 32'(delivered - d0), 32'd1);

    // Reset with three words buffered and one still in flight
    pushWords(3);
    repeat (6) applyStimulus(1'b0, 1'b1);
    pushWords(1);
    applyStimulus(1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0);
    repeat (4) applyStimulus(1'b1, 1'b1);
    d0 = delivered;
    pushWords(4);
    repeat (12) applyStimulus(1'b1, 1'b1);
    checkOutput("post_reset_count", 32'(delivered - d0), 32'd4);

    // Random traffic, random backpressure and occasional resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) pushWords(int'($urandom_range(3, 1)));
      applyStimulus(logic'($urandom_range(1)), logic'($urandom_range(199) != 0));
    end
    repeat (40) applyStimulus(1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
